scan_display: RTL and testbench

Parameterised multiplexed seven-segment driver for DIGITS common-anode digits. It is the successor to the fixed 4-digit scanner and adds:
- generic digit count,
- double-buffered value loading that only changes at frame boundaries,
- leading-zero blanking,
- per-digit decimal points,
- PWM brightness control with an anti-ghosting guard cycle.

It sits between the application's hex value source and the board's segment/select pins.

---
 rtl/scan_display_pkg.sv | 51 +++++
 rtl/scan_display_timer.sv | 67 ++++++
 rtl/seven_segment_formatter.sv | 18 +
 rtl/scan_display.sv | 173 +++++++++++++++++
 tb/tb_scan_display.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_display_pkg.sv
// +-----------------------------------------------------------------------------+
// | scan_display_pkg : shared constants, helpers and hex->segment table.        |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

package scan_display_pkg;

  localparam int unsigned MAX_DIGITS = 32;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  // All-ones select pattern for a display of the given width (right-aligned).
  function automatic logic [MAX_DIGITS-1:0] select_off(input int unsigned digits);
    logic [MAX_DIGITS-1:0] ones;
    ones = '1;
    return ones >> (MAX_DIGITS - digits);
  endfunction

  function automatic int unsigned slot_cycles(input int unsigned clock_speed,
                                              input int unsigned framerate,
                                              input int unsigned digits);
    return clock_speed / framerate / digits;
  endfunction

  // Active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_display_timer.sv
// +-----------------------------------------------------------------------------+
// | scan_display_timer : slot/digit scan counters, frame boundary, blink phase.|
// | Optional SCAN_DISPLAY_BLINK_EN adds the blink frame counter. Revision 1.0  |
// +-----------------------------------------------------------------------------+
`default_nettype none

module scan_display_timer #(
  parameter int unsigned SLOT_CYCLES  = 16,
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SLOT_W       = 4,
  parameter int unsigned DIG_W        = 2
`ifdef SCAN_DISPLAY_BLINK_EN
  , parameter int unsigned BLINK_FRAMES = 250
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic [DIG_W-1:0]  dig,
`ifdef SCAN_DISPLAY_BLINK_EN
  output logic              blink_phase,
`endif
  output logic              frame_boundary
);

  logic slot_wrap;
  logic dig_wrap;

  assign slot_wrap      = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
  assign dig_wrap       = (dig == DIG_W'(DIGITS - 1));
  assign frame_boundary = slot_wrap && dig_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig      <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      dig      <= dig_wrap ? '0 : dig + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

`ifdef SCAN_DISPLAY_BLINK_EN
  localparam int unsigned BC_W = $clog2(BLINK_FRAMES + 1);

  logic [BC_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_boundary) begin
      if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/seven_segment_formatter.sv
// +-----------------------------------------------------------------------------+
// | seven_segment_formatter : combinational hex nibble to active-low segments. |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module seven_segment_formatter
  import scan_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segments
);

  assign segments = hex_to_seg(hex);

endmodule

`default_nettype wire

// File: rtl/scan_display.sv
// +-----------------------------------------------------------------------------+
// | scan_display : multiplexed common-anode 7-seg driver with frame-aligned    |
// | double buffering, LZ blanking, DPs and PWM brightness. Optional feature:   |
// | SCAN_DISPLAY_BLINK_EN (per-digit blink). Revision 1.0                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module scan_display
  import scan_display_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED     = 0,
  parameter int unsigned FRAMERATE       = 1000,
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned BRIGHTNESS_BITS = 4
`ifdef SCAN_DISPLAY_BLINK_EN
  , parameter int unsigned BLINK_FRAMES  = 250
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [4*DIGITS-1:0]        value,
  input  logic [DIGITS-1:0]          dp,
  input  logic                       load,
  input  logic                       lz_blank,
  input  logic [BRIGHTNESS_BITS-1:0] brightness,
`ifdef SCAN_DISPLAY_BLINK_EN
  input  logic [DIGITS-1:0]          blink,
`endif
  output logic [6:0]                 seven_segment,
  output logic                       seven_segment_dp,
  output logic [DIGITS-1:0]          seven_segment_select
);

  localparam int unsigned SLOT_CYCLES = slot_cycles(CLOCK_SPEED, FRAMERATE, DIGITS);
  localparam int unsigned SLOT_W      = $clog2((SLOT_CYCLES < 2) ? 2 : SLOT_CYCLES);
  localparam int unsigned DIG_W       = $clog2(DIGITS);
  localparam logic [MAX_DIGITS-1:0] SEL_OFF_ALL = select_off(DIGITS);
  localparam logic [DIGITS-1:0]     SEL_OFF     = SEL_OFF_ALL[DIGITS-1:0];

  if ((SLOT_CYCLES < 2**BRIGHTNESS_BITS) || (DIGITS < 2) || (DIGITS > MAX_DIGITS)) begin : g_bad_config
    $error("scan_display: SLOT_CYCLES must be >= 2**BRIGHTNESS_BITS and 2 <= DIGITS <= 32");
  end

  logic [SLOT_W-1:0]   slot_cnt;
  logic [DIG_W-1:0]    dig;
  logic                frame_boundary;
  logic                blink_dark;

  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] pending;
  logic [DIGITS-1:0]   pending_dp;
  logic                pend_valid;

  logic [3:0]          nib [DIGITS];
  logic [DIGITS:1]     zero_from;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   one_hot;
  logic [6:0]          seg_dec;
  logic                lit;

`ifdef SCAN_DISPLAY_BLINK_EN
  logic                blink_phase;
  logic [DIGITS-1:0]   shadow_blink;
  logic [DIGITS-1:0]   pending_blink;
`endif

  scan_display_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .DIGITS      (DIGITS),
    .SLOT_W      (SLOT_W),
    .DIG_W       (DIG_W)
`ifdef SCAN_DISPLAY_BLINK_EN
    , .BLINK_FRAMES(BLINK_FRAMES)
`endif
  ) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .slot_cnt       (slot_cnt),
    .dig            (dig),
`ifdef SCAN_DISPLAY_BLINK_EN
    .blink_phase    (blink_phase),
`endif
    .frame_boundary (frame_boundary)
  );

  // A load landing on the boundary cycle goes straight to the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= '0;
      pending_dp <= '0;
      pend_valid <= 1'b0;
    end else if (frame_boundary) begin
      pend_valid <= 1'b0;
      if (load) begin
        shadow    <= value;
        shadow_dp <= dp;
      end else if (pend_valid) begin
        shadow    <= pending;
        shadow_dp <= pending_dp;
      end
    end else if (load) begin
      pending    <= value;
      pending_dp <= dp;
      pend_valid <= 1'b1;
    end
  end

`ifdef SCAN_DISPLAY_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_blink  <= '0;
      pending_blink <= '0;
    end else if (frame_boundary) begin
      if (load) begin
        shadow_blink <= blink;
      end else if (pend_valid) begin
        shadow_blink <= pending_blink;
      end
    end else if (load) begin
      pending_blink <= blink;
    end
  end

  assign blink_dark = blink_phase && shadow_blink[dig];
`else
  assign blink_dark = 1'b0;
`endif

  // zero_from[i] is set when nibbles i..DIGITS-1 are all zero.
  assign zero_from[DIGITS] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign nib[i] = shadow[4*i +: 4];
    if (i == 0) begin : g_first
      assign blank[i] = 1'b0;
    end else begin : g_upper
      assign zero_from[i] = (nib[i] == 4'h0) && zero_from[i+1];
      assign blank[i]     = lz_blank && zero_from[i] && !shadow_dp[i];
    end
  end

  seven_segment_formatter u_fmt (
    .hex      (nib[dig]),
    .segments (seg_dec)
  );

  assign one_hot = DIGITS'(1) << (DIG_W'(DIGITS - 1) - dig);
  assign lit     = (slot_cnt != '0) && (brightness != '0) &&
                   (slot_cnt[BRIGHTNESS_BITS-1:0] <= brightness) &&
                   !blank[dig] && !blink_dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seven_segment_select <= SEL_OFF;
      seven_segment        <= SEG_OFF;
      seven_segment_dp     <= 1'b1;
    end else if (lit) begin
      seven_segment_select <= SEL_OFF ^ one_hot;
      seven_segment        <= seg_dec;
      seven_segment_dp     <= ~shadow_dp[dig];
    end else begin
      seven_segment_select <= SEL_OFF;
      seven_segment        <= SEG_OFF;
      seven_segment_dp     <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scan_display.sv
// +-----------------------------------------------------------------------------+
// | tb_scan_display : scoreboard bench, frame-level reference model.            |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_scan_display;

  localparam int unsigned CLK_HZ = 64000;
  localparam int unsigned FPS    = 1000;
  localparam int unsigned D      = 4;
  localparam int unsigned BB     = 4;
  localparam int unsigned SLOT   = 16;
  localparam int unsigned FRAME  = SLOT * D;
`ifdef SCAN_DISPLAY_BLINK_EN
  localparam int unsigned BF       = 2;
  localparam bit          BLINK_EN = 1'b1;
`else
  localparam int unsigned BF       = 1;
  localparam bit          BLINK_EN = 1'b0;
`endif
  localparam logic [11:0] OFF = {4'hF, 7'h7F, 1'b1};
  // Active-high gfedcba patterns for 0..F.
  localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic [3:0]  blink;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  sel;

  int checks = 0;
  int errors = 0;

  int unsigned t = 0;
  logic [15:0] m_shadow = '0, m_pend = '0;
  logic [3:0]  m_sdp = '0, m_pdp = '0, m_sblink = '0, m_pblink = '0;
  bit          m_pv = 1'b0;
  logic [11:0] exp_q [$];

  scan_display #(
    .CLOCK_SPEED     (CLK_HZ),
    .FRAMERATE       (FPS),
    .DIGITS          (D),
    .BRIGHTNESS_BITS (BB)
`ifdef SCAN_DISPLAY_BLINK_EN
    , .BLINK_FRAMES  (BF)
`endif
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .value                (value),
    .dp                   (dp),
    .load                 (load),
    .lz_blank             (lz_blank),
    .brightness           (brightness),
`ifdef SCAN_DISPLAY_BLINK_EN
    .blink                (blink),
`endif
    .seven_segment        (seg),
    .seven_segment_dp     (seg_dp),
    .seven_segment_select (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position in the frame is plain arithmetic on the cycle count.
  always @(posedge clk) begin
    int p, d;
    bit boundary, blank, dark_blink, lit;
    logic [15:0] upper;
    logic [11:0] e;
    if (!rst_n) begin
      exp_q.push_back(OFF);
      t = 0; m_shadow = '0; m_pend = '0; m_sdp = '0; m_pdp = '0;
      m_sblink = '0; m_pblink = '0; m_pv = 1'b0;
    end else begin
      p          = int'(t % SLOT);
      d          = int'((t / SLOT) % D);
      boundary   = (t % FRAME) == FRAME - 1;
      upper      = m_shadow >> (4 * d);
      blank      = lz_blank && (d != 0) && !m_sdp[d] && (upper == 16'h0);
      dark_blink = BLINK_EN && (((t / FRAME / BF) % 2) == 1) && m_sblink[d];
      lit        = (p != 0) && (brightness != 0) && (p <= int'(brightness)) && !blank && !dark_blink;
      if (lit) e = {~(4'b0001 << (D - 1 - d)), ~SEG_ON[upper[3:0]], ~m_sdp[d]};
      else     e = OFF;
      exp_q.push_back(e);
      if (boundary) begin
        if (load) begin
          m_shadow = value; m_sdp = dp; m_sblink = blink;
        end else if (m_pv) begin
          m_shadow = m_pend; m_sdp = m_pdp; m_sblink = m_pblink;
        end
        m_pv = 1'b0;
      end else if (load) begin
        m_pend = value; m_pdp = dp; m_pblink = blink; m_pv = 1'b1;
      end
      t++;
    end
  end

  // Monitor: the outputs are presented every cycle; compare each one.
  always @(posedge clk) begin
    logic [11:0] exp_v, got;
    #1;
    checks++;
    got = {sel, seg, seg_dp};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got sel=%b seg=%h dp=%b, expected an entry", sel, seg, seg_dp);
    end else begin
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0d: got sel=%b seg=%h dp=%b, expected sel=%b seg=%h dp=%b",
                 t, got[11:8], got[7:1], got[0], exp_v[11:8], exp_v[7:1], exp_v[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    value = v; dp = d; blink = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0; value = 16'($urandom); dp = 4'($urandom); blink = 4'($urandom);
  endtask

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    @(negedge clk);
    while (int'(t % FRAME) != pos && n < 4 * int'(FRAME)) begin
      @(negedge clk);
      n++;
    end
    if (int'(t % FRAME) != pos) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: frame position %0d, expected %0d", t % FRAME, pos);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst_n = 1'b0; value = '0; dp = '0; load = 1'b0; lz_blank = 1'b0;
    brightness = 4'd15; blink = '0;
    tick(3);
    rst_n = 1'b1;

    do_load(16'h1234, 4'b0000, 4'b0001);
    tick(2 * FRAME);

    wait_pos(SLOT + 3);
    do_load(16'h00A5, 4'b0000, 4'b0000);
    tick(10);
    do_load(16'h0007, 4'b0000, 4'b0000);
    tick(2 * FRAME);

    lz_blank = 1'b1;
    tick(FRAME + 5);
    do_load(16'h0000, 4'b0000, 4'b0000);
    tick(FRAME + 20);
    do_load(16'h0000, 4'b0100, 4'b0000);
    tick(FRAME + 20);
    lz_blank = 1'b0;

    // Load landing exactly on the boundary cycle.
    wait_pos(FRAME - 2);
    do_load(16'hBEEF, 4'b1001, 4'b0000);
    tick(FRAME);

    do_load(16'h1234, 4'b0000, 4'b0000);
    brightness = 4'd0;
    tick(FRAME + 10);
    brightness = 4'd4;
    tick(FRAME + 10);
    brightness = 4'd15;
    tick(FRAME);

    // Asynchronous reset mid-slot at dig=2, slot_cnt=9.
    wait_pos(2 * SLOT + 9);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, seg, seg_dp} !== OFF) begin
      errors++;
      $display("FAIL async_reset: got sel=%b seg=%h dp=%b, expected all off", sel, seg, seg_dp);
    end
    tick(2);
    rst_n = 1'b1;
    tick(FRAME + 10);

    do_load(16'h1234, 4'b0000, 4'b0001);
    tick(6 * FRAME);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      load = 1'b0;
      r = int'($urandom_range(0, 199));
      if (r < 12) begin
        case ($urandom_range(0, 4))
          0: value = 16'($urandom);
          1: value = 16'($urandom) & 16'h0FFF;
          2: value = 16'($urandom) & 16'h00FF;
          3: value = 16'($urandom) & 16'h000F;
          default: value = 16'h0000;
        endcase
        dp = 4'($urandom); blink = 4'($urandom); load = 1'b1;
      end else if (r < 16) begin
        brightness = 4'($urandom);
      end else if (r < 19) begin
        lz_blank = ~lz_blank;
      end else if (r == 19) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    load = 1'b0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
